// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//   Multicycle controller for the serial shift register datapath. It accepts one
//   shift/rotate command and parallel-loads the operand into the shift register.
//   It then issues exactly 'amt' single-bit shifts, each with the correct serial
//   input bit, and pulses o_done while the shift register holds the result.
//
//   State flow: IDLE -> LOAD -> SHIFT (amt cycles) -> DONE -> IDLE.
//   When amt is 0 or the op is illegal, the flow goes LOAD -> DONE directly.
//
// Parameters
//   W   operand / shift-register width (>= 2)
//   AW  width of the shift amount (amt range 0 .. 2**AW-1)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset (shared with the shift register)
//   i_start     command strobe, sampled only in IDLE
//   i_op        000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 illegal
//   i_amt       number of single-bit shifts
//   i_din       operand
//   i_abort     (only with SHIFT_ABORT_EN) drop the command in LOAD/SHIFT
//   o_busy      high in every state except IDLE
//   o_done      one-cycle pulse in DONE
//   o_err       high together with o_done when the captured op was illegal
//   o_result    shift-register contents, valid while o_done = 1
//   o_sr_in     parallel load data for the shift register (captured operand)
//   o_sr_write  shift-register write enable
//   o_sr_sps    1 = parallel load, 0 = shift
//   o_sr_srl    1 = shift right, 0 = shift left
//   o_sr_sin    serial input bit
//   i_sr_q      shift-register output, used as feedback for SRA and rotates
//
// Configuration
//   SHIFT_ABORT_EN  when defined, adds the i_abort port. An abort in LOAD or
//                   SHIFT returns the FSM to IDLE without a done pulse, and the
//                   shift register keeps its partial value. rst still wins.
// -----------------------------------------------------------------------------
module shift_sequencer #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [2:0]    i_op,
  input  logic [AW-1:0] i_amt,
  input  logic [W-1:0]  i_din,
`ifdef SHIFT_ABORT_EN
  input  logic          i_abort,
`endif
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [W-1:0]  o_result,
  output logic [W-1:0]  o_sr_in,
  output logic          o_sr_write,
  output logic          o_sr_sps,
  output logic          o_sr_srl,
  output logic          o_sr_sin,
  input  logic [W-1:0]  i_sr_q
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  state_t        r_state;
  state_t        w_next_state;
  logic [2:0]    r_op;
  logic [AW-1:0] r_cnt;
  logic [W-1:0]  r_din;
  logic          w_illegal;
  logic          w_abort;

  assign w_illegal = (r_op > OP_ROR);

`ifdef SHIFT_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_cnt   <= '0;
      r_din   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && i_start) begin
        r_op  <= i_op;
        r_cnt <= i_amt;
        r_din <= i_din;
      end else if (r_state == S_SHIFT) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // NOTE: every signal written here gets a default first. That way no path
  // through the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    o_sr_write   = 1'b0;
    o_sr_sps     = 1'b0;
    o_sr_srl     = 1'b0;
    o_sr_sin     = 1'b0;
    o_done       = 1'b0;
    o_err        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        o_sr_write = ~w_abort;
        o_sr_sps   = 1'b1;
        if (w_abort)                            w_next_state = S_IDLE;
        else if (r_cnt == '0 || w_illegal)      w_next_state = S_DONE;
        else                                    w_next_state = S_SHIFT;
      end
      S_SHIFT: begin
        o_sr_write = ~w_abort;
        // Feedback bits are taken from the register as it is this cycle. The
        // rotate/arith fill is therefore correct for every step, including amt >= W.
        case (r_op)
          OP_SRL:  begin o_sr_srl = 1'b1; o_sr_sin = 1'b0;        end
          OP_SRA:  begin o_sr_srl = 1'b1; o_sr_sin = i_sr_q[W-1]; end
          OP_ROL:  begin o_sr_srl = 1'b0; o_sr_sin = i_sr_q[W-1]; end
          OP_ROR:  begin o_sr_srl = 1'b1; o_sr_sin = i_sr_q[0];   end
          default: begin o_sr_srl = 1'b0; o_sr_sin = 1'b0;        end
        endcase
        if (w_abort)              w_next_state = S_IDLE;
        else if (r_cnt == AW'(1)) w_next_state = S_DONE;
      end
      S_DONE: begin
        o_done       = 1'b1;
        o_err        = w_illegal;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign o_busy   = (r_state != S_IDLE);
  assign o_result = i_sr_q;
  assign o_sr_in  = r_din;

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
//   Drives shift_sequencer (W=8, AW=4) against a behavioural shift register.
//   A table of commands with hand-computed results is replayed back to back.
//   Each expectation is queued when its command is issued and compared when
//   o_done fires. Hand-written sequences cover start flooding, reset
//   mid-shift and, with SHIFT_ABORT_EN, abort.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;
  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [2:0]    i_op = '0;
  logic [AW-1:0] i_amt = '0;
  logic [W-1:0]  i_din = '0;
  logic          i_abort = 1'b0;
  logic          o_busy, o_done, o_err, o_sr_write, o_sr_sps, o_sr_srl, o_sr_sin;
  logic [W-1:0]  o_result, o_sr_in;
  logic [W-1:0]  sr_q;

  always #5 clk = ~clk;

  shift_sequencer #(.W(W), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_amt      (i_amt),
    .i_din      (i_din),
`ifdef SHIFT_ABORT_EN
    .i_abort    (i_abort),
`endif
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_result   (o_result),
    .o_sr_in    (o_sr_in),
    .o_sr_write (o_sr_write),
    .o_sr_sps   (o_sr_sps),
    .o_sr_srl   (o_sr_srl),
    .o_sr_sin   (o_sr_sin),
    .i_sr_q     (sr_q)
  );

  // Behavioural serial shift register datapath (shares rst with the sequencer).
  always @(posedge clk) begin
    if (rst)               sr_q <= '0;
    else if (o_sr_write) begin
      if (o_sr_sps)        sr_q <= o_sr_in;
      else if (o_sr_srl)   sr_q <= {o_sr_sin, sr_q[W-1:1]};
      else                 sr_q <= {sr_q[W-2:0], o_sr_sin};
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int done_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] result;
    logic         err;
  } exp_t;
  exp_t sb[$];

  // Scoreboard monitor: every done pulse must match the oldest queued command.
  always @(negedge clk) begin
    if (!rst && o_done) begin
      done_count++;
      if (sb.size() == 0) begin
        check("unexpected_done", {31'd0, o_done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_result", {24'd0, o_result}, {24'd0, e.result});
        check("sb_err", {31'd0, o_err}, {31'd0, e.err});
      end
    end
  end

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic [W-1:0]  din;
    logic [W-1:0]  result;
    logic          err;
  } vec_t;
  vec_t vecs[12];

  // Issue one command and follow it through LOAD and the first SHIFT to done.
  // Returns with the bench on the negedge of the DONE cycle (or after timeout).
  task automatic run_cmd(input vec_t v, input int idx);
    int  n;
    int  exp_lat;
    logic illegal;
    logic exp_srl, exp_sin;
    illegal = (v.op > 3'd4);
    exp_lat = (illegal || v.amt == 0) ? 2 : int'(v.amt) + 2;
    exp_srl = (v.op == 3'd1 || v.op == 3'd2 || v.op == 3'd4);
    case (v.op)
      3'd2, 3'd3: exp_sin = v.din[W-1];
      3'd4:       exp_sin = v.din[0];
      default:    exp_sin = 1'b0;
    endcase
    @(negedge clk);
    i_start = 1'b1; i_op = v.op; i_amt = v.amt; i_din = v.din;
    sb.push_back('{result: v.result, err: v.err});
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    n = 1;
    check($sformatf("v%0d_load_write", idx), {31'd0, o_sr_write}, 32'd1);
    check($sformatf("v%0d_load_sps", idx),   {31'd0, o_sr_sps},   32'd1);
    check($sformatf("v%0d_load_in", idx),    {24'd0, o_sr_in},    {24'd0, v.din});
    while (!o_done && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n == 2 && !illegal && v.amt != 0) begin
        check($sformatf("v%0d_shift_srl", idx), {31'd0, o_sr_srl}, {31'd0, exp_srl});
        check($sformatf("v%0d_shift_sin", idx), {31'd0, o_sr_sin}, {31'd0, exp_sin});
        check($sformatf("v%0d_shift_sps", idx), {31'd0, o_sr_sps}, 32'd0);
      end
    end
    check($sformatf("v%0d_latency", idx), n, exp_lat);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    int n;
    //          op     amt    din    result err
    vecs[0]  = '{3'd0, 4'd1,  8'h81, 8'h02, 1'b0};  // SLL
    vecs[1]  = '{3'd2, 4'd2,  8'h90, 8'hE4, 1'b0};  // SRA sign fill
    vecs[2]  = '{3'd4, 4'd3,  8'h01, 8'h20, 1'b0};  // ROR
    vecs[3]  = '{3'd3, 4'd9,  8'h80, 8'h01, 1'b0};  // ROL wraps past W
    vecs[4]  = '{3'd1, 4'd0,  8'hA5, 8'hA5, 1'b0};  // amt=0
    vecs[5]  = '{3'd7, 4'd5,  8'h3C, 8'h3C, 1'b1};  // illegal
    vecs[6]  = '{3'd0, 4'd15, 8'hFF, 8'h00, 1'b0};  // SLL amt>W
    vecs[7]  = '{3'd2, 4'd15, 8'h80, 8'hFF, 1'b0};  // SRA amt>W
    vecs[8]  = '{3'd1, 4'd4,  8'hF0, 8'h0F, 1'b0};  // SRL
    vecs[9]  = '{3'd4, 4'd12, 8'hA5, 8'h5A, 1'b0};  // ROR amt>W
    vecs[10] = '{3'd5, 4'd0,  8'h11, 8'h11, 1'b1};  // illegal, amt=0
    vecs[11] = '{3'd2, 4'd3,  8'h70, 8'h0E, 1'b0};  // SRA positive

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  {31'd0, o_busy},     32'd0);
    check("rst_done",  {31'd0, o_done},     32'd0);
    check("rst_err",   {31'd0, o_err},      32'd0);
    check("rst_write", {31'd0, o_sr_write}, 32'd0);
    check("rst_sps",   {31'd0, o_sr_sps},   32'd0);
    check("rst_srl",   {31'd0, o_sr_srl},   32'd0);
    check("rst_sin",   {31'd0, o_sr_sin},   32'd0);
    check("rst_in",    {24'd0, o_sr_in},    32'd0);
    rst = 1'b0;

    // Table of commands, issued back to back.
    foreach (vecs[i]) run_cmd(vecs[i], i);
    @(negedge clk);
    check("idle_after_table_busy", {31'd0, o_busy}, 32'd0);
    check("idle_hold_result", {24'd0, sr_q}, {24'd0, vecs[11].result});

    // Start held high with changing inputs during SLL 0x03 amt=4.
    d0 = done_count;
    @(negedge clk);
    i_start = 1'b1; i_op = 3'd0; i_amt = 4'd4; i_din = 8'h03;
    sb.push_back('{result: 8'h30, err: 1'b0});
    @(posedge clk);
    n = 1;
    @(negedge clk);
    while (!o_done && n < 40) begin
      i_op = 3'($urandom_range(0, 7)); i_amt = 4'($urandom); i_din = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    i_start = 1'b0;
    check("flood_latency", n, 6);
    repeat (4) @(negedge clk);
    check("flood_single_done", done_count - d0, 1);
    check("flood_idle", {31'd0, o_busy}, 32'd0);

    // Reset asserted in the second SHIFT cycle of SLL 0x01 amt=6.
    d0 = done_count;
    @(negedge clk);
    i_start = 1'b1; i_op = 3'd0; i_amt = 4'd6; i_din = 8'h01;
    @(posedge clk);
    @(negedge clk);  // LOAD
    i_start = 1'b0;
    @(negedge clk);  // SHIFT 1
    @(negedge clk);  // SHIFT 2
    check("pre_rst_busy", {31'd0, o_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    check("mid_rst_srq", {24'd0, sr_q}, 32'd0);
    check("mid_rst_done", {31'd0, o_done}, 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_rst_no_done", done_count - d0, 0);

`ifdef SHIFT_ABORT_EN
    // Abort in the second SHIFT cycle of SLL 0x01 amt=5: one shift lands.
    d0 = done_count;
    @(negedge clk);
    i_start = 1'b1; i_op = 3'd0; i_amt = 4'd5; i_din = 8'h01;
    @(posedge clk);
    @(negedge clk);  // LOAD
    i_start = 1'b0;
    @(negedge clk);  // SHIFT 1
    @(negedge clk);  // SHIFT 2
    i_abort = 1'b1;
    #1;
    check("abort_write", {31'd0, o_sr_write}, 32'd0);
    @(negedge clk);
    i_abort = 1'b0;
    check("abort_busy", {31'd0, o_busy}, 32'd0);
    check("abort_srq", {24'd0, sr_q}, 32'h02);
    repeat (4) @(negedge clk);
    check("abort_hold", {24'd0, sr_q}, 32'h02);
    check("abort_no_done", done_count - d0, 0);
`endif

    // A command after the disturbances still works.
    run_cmd('{3'd3, 4'd2, 8'hC1, 8'h07, 1'b0}, 99);
    @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
